// File: rtl/pattern_det_ctrl.sv
// pattern_det_ctrl: configurable serial pattern detector controller with match counting and completion flag
module pattern_det_ctrl #(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = 4,
    parameter int CNT_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic [CNT_W-1:0]   cfg_thresh,
    output logic               cfg_err,
    input  logic               start,
    input  logic               stop,
    input  logic               signal,
    input  logic               sig_valid,
    output logic               out,
    output logic [CNT_W-1:0]   match_cnt,
    output logic               busy,
    output logic               done
);
    typedef enum logic [1:0] {IDLE, ARMED, DONE} state_t;
    state_t state, state_nx;
    logic [MAX_LEN-1:0] pattern, shifted, mask;
    logic [MAX_LEN-2:0] history;
    logic [LEN_W-1:0]   len, fill, fill_inc;
    logic [CNT_W-1:0]   thresh, cnt_inc;
    logic               overlap, cfg_fire, cfg_ok, bit_en, hit, arm;

    // Handshake, window compare and start qualification derived from current state
    always_comb begin
        cfg_ready = state == IDLE;
        busy      = state == ARMED;
        done      = state == DONE;
        cfg_fire  = cfg_valid && cfg_ready;
        cfg_ok    = cfg_len != '0 && cfg_len <= LEN_W'(MAX_LEN);
        bit_en    = busy && sig_valid;
        shifted   = {history, signal};
        mask      = '0;
        for (int i = 0; i < MAX_LEN; i++) mask[i] = i < int'(len);
        hit       = bit_en && ({1'b0, fill} + (LEN_W+1)'(1) >= {1'b0, len}) &&
                    ((shifted ^ pattern) & mask) == '0;
        fill_inc  = fill < len ? fill + LEN_W'(1) : len;
        cnt_inc   = &match_cnt ? match_cnt : match_cnt + CNT_W'(1);
        arm       = start && !stop && (cfg_ready ? len != '0 : done);
    end

    // Next state: stop wins, then start, then threshold completion
    always_comb begin
        state_nx = state;
        if (stop && state != IDLE)
            state_nx = IDLE;
        else if (arm)
            state_nx = ARMED;
        else if (hit && thresh != '0 && cnt_inc == thresh)
            state_nx = DONE;
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // Config capture, shift history, fill tracking, match counting and pulses
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pattern   <= '0;
            len       <= '0;
            overlap   <= 1'b0;
            thresh    <= '0;
            history   <= '0;
            fill      <= '0;
            match_cnt <= '0;
            out       <= 1'b0;
            cfg_err   <= 1'b0;
        end else begin
            cfg_err <= cfg_fire && !cfg_ok;
            out     <= hit;
            if (cfg_fire && cfg_ok) begin
                pattern <= cfg_pattern;
                len     <= cfg_len;
                overlap <= cfg_overlap;
                thresh  <= cfg_thresh;
            end
            if (arm) begin
                history   <= '0;
                fill      <= '0;
                match_cnt <= '0;
            end else if (bit_en) begin
                history <= shifted[MAX_LEN-2:0];
                fill    <= (hit && !overlap) ? '0 : fill_inc;
                if (hit) match_cnt <= cnt_inc;
            end
        end
    end
endmodule

// File: tb/tb_pattern_det_ctrl.sv
// tb_pattern_det_ctrl: table-driven scoreboard bench for pattern_det_ctrl
module tb_pattern_det_ctrl;
    logic       clk = 0, rst = 0, cfg_valid = 0, cfg_overlap = 0, start = 0, stop = 0;
    logic       signal = 0, sig_valid = 0;
    logic       cfg_ready, cfg_err, out, busy, done;
    logic [7:0] cfg_pattern = 0, cfg_thresh = 0, match_cnt;
    logic [3:0] cfg_len = 0;

    typedef struct {
        logic       cv;
        logic [7:0] pat;
        logic [3:0] len;
        logic       ov;
        logic [7:0] th;
        logic       st, sp, sv, sig;
        logic       e_out;
        logic [7:0] e_cnt;
        logic       e_busy, e_done, e_err;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];
    vec_t e;
    int   nvec = 0, nfail = 0, row = 0;
    logic [7:0] p8 = 8'b10110011;

    always #5 clk = ~clk;

    pattern_det_ctrl dut (
        .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
        .cfg_thresh(cfg_thresh), .cfg_err(cfg_err), .start(start), .stop(stop),
        .signal(signal), .sig_valid(sig_valid), .out(out), .match_cnt(match_cnt),
        .busy(busy), .done(done)
    );

    function automatic vec_t r(int cv, int pat, int len, int ov, int th, int st, int sp,
                               int sv, int sig, int eo, int ec, int eb, int ed, int ee);
        vec_t v;
        v.cv = 1'(cv); v.pat = 8'(pat); v.len = 4'(len); v.ov = 1'(ov); v.th = 8'(th);
        v.st = 1'(st); v.sp = 1'(sp); v.sv = 1'(sv); v.sig = 1'(sig);
        v.e_out = 1'(eo); v.e_cnt = 8'(ec); v.e_busy = 1'(eb); v.e_done = 1'(ed); v.e_err = 1'(ee);
        return v;
    endfunction

    function automatic vec_t b(int sv, int sig, int eo, int ec, int eb, int ed);
        return r(0, 0, 0, 0, 0, 0, 0, sv, sig, eo, ec, eb, ed, 0);
    endfunction

    function automatic vec_t s(int st, int sp, int eo, int ec, int eb, int ed);
        return r(0, 0, 0, 0, 0, st, sp, 0, 0, eo, ec, eb, ed, 0);
    endfunction

    function automatic vec_t k(int pat, int len, int ov, int th, int ec, int ee);
        return r(1, pat, len, ov, th, 0, 0, 0, 0, 0, ec, 0, 0, ee);
    endfunction

    task automatic cmp(string nm, logic [31:0] act, logic [31:0] want);
        nvec++;
        if (act !== want) begin
            nfail++;
            $display("FAIL row %0d %s: got %0d want %0d", row, nm, act, want);
        end
    endtask

    task automatic drive(vec_t v);
        @(negedge clk);
        cfg_valid = v.cv; cfg_pattern = v.pat; cfg_len = v.len; cfg_overlap = v.ov;
        cfg_thresh = v.th; start = v.st; stop = v.sp; sig_valid = v.sv; signal = v.sig;
        exp_q.push_back(v);
    endtask

    task automatic drain();
        @(posedge clk);
        #2;
        cmp("scoreboard_drained", 32'(exp_q.size()), 0);
        {cfg_valid, start, stop, sig_valid, signal} = '0;
    endtask

    // Scoreboard: pop the expectation for each driven cycle just after the edge
    always @(posedge clk) begin
        #1;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            row++;
            cmp("out", 32'(out), 32'(e.e_out));
            cmp("match_cnt", 32'(match_cnt), 32'(e.e_cnt));
            cmp("busy", 32'(busy), 32'(e.e_busy));
            cmp("done", 32'(done), 32'(e.e_done));
            cmp("cfg_err", 32'(cfg_err), 32'(e.e_err));
            cmp("cfg_ready", 32'(cfg_ready), 32'(!(e.e_busy || e.e_done)));
        end
    end

    initial begin
        // T1 overlap 101
        vecs.push_back(k(5, 3, 1, 0, 0, 0));
        vecs.push_back(s(1, 0, 0, 0, 1, 0));
        vecs.push_back(b(1, 1, 0, 0, 1, 0)); vecs.push_back(b(1, 0, 0, 0, 1, 0));
        vecs.push_back(b(1, 1, 1, 1, 1, 0)); vecs.push_back(b(1, 0, 0, 1, 1, 0));
        vecs.push_back(b(1, 1, 1, 2, 1, 0));
        vecs.push_back(s(0, 1, 0, 2, 0, 0));
        // T2 non-overlap 101
        vecs.push_back(k(5, 3, 0, 0, 2, 0));
        vecs.push_back(s(1, 0, 0, 0, 1, 0));
        vecs.push_back(b(1, 1, 0, 0, 1, 0)); vecs.push_back(b(1, 0, 0, 0, 1, 0));
        vecs.push_back(b(1, 1, 1, 1, 1, 0)); vecs.push_back(b(1, 0, 0, 1, 1, 0));
        vecs.push_back(b(1, 1, 0, 1, 1, 0)); vecs.push_back(b(1, 0, 0, 1, 1, 0));
        vecs.push_back(b(1, 1, 1, 2, 1, 0));
        vecs.push_back(s(0, 1, 0, 2, 0, 0));
        // T3 threshold 2
        vecs.push_back(k(5, 3, 1, 2, 2, 0));
        vecs.push_back(s(1, 0, 0, 0, 1, 0));
        vecs.push_back(b(1, 1, 0, 0, 1, 0)); vecs.push_back(b(1, 0, 0, 0, 1, 0));
        vecs.push_back(b(1, 1, 1, 1, 1, 0)); vecs.push_back(b(1, 0, 0, 1, 1, 0));
        vecs.push_back(b(1, 1, 1, 2, 0, 1)); vecs.push_back(b(1, 0, 0, 2, 0, 1));
        vecs.push_back(b(1, 1, 0, 2, 0, 1));
        // T4 restart from DONE, invalid bits interleaved
        vecs.push_back(s(1, 0, 0, 0, 1, 0));
        vecs.push_back(b(1, 1, 0, 0, 1, 0)); vecs.push_back(b(0, 1, 0, 0, 1, 0));
        vecs.push_back(b(1, 0, 0, 0, 1, 0)); vecs.push_back(b(0, 0, 0, 0, 1, 0));
        vecs.push_back(b(1, 1, 1, 1, 1, 0));
        // T5 config while ARMED ignored, then illegal lengths in IDLE
        vecs.push_back(r(1, 255, 2, 0, 1, 0, 0, 0, 0, 0, 1, 1, 0, 0));
        vecs.push_back(b(1, 0, 0, 1, 1, 0));
        vecs.push_back(b(1, 1, 1, 2, 0, 1));
        vecs.push_back(s(0, 1, 0, 2, 0, 0));
        vecs.push_back(k(3, 9, 0, 1, 2, 1));
        vecs.push_back(k(1, 0, 0, 1, 2, 1));
        vecs.push_back(s(0, 0, 0, 2, 0, 0));
        vecs.push_back(s(1, 0, 0, 0, 1, 0));
        vecs.push_back(b(1, 1, 0, 0, 1, 0)); vecs.push_back(b(1, 1, 0, 0, 1, 0));
        vecs.push_back(b(1, 0, 0, 0, 1, 0)); vecs.push_back(b(1, 1, 1, 1, 1, 0));
        vecs.push_back(b(1, 0, 0, 1, 1, 0));
        vecs.push_back(r(0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 2, 0, 0, 0));
        // saturation with a 1-bit pattern
        vecs.push_back(k(1, 1, 0, 0, 2, 0));
        vecs.push_back(s(1, 0, 0, 0, 1, 0));
        for (int i = 0; i < 260; i++) vecs.push_back(b(1, 1, 1, i < 255 ? i + 1 : 255, 1, 0));
        vecs.push_back(s(0, 1, 0, 255, 0, 0));
        // full-length pattern, non-overlap, two back-to-back occurrences
        vecs.push_back(k(int'(p8), 8, 0, 0, 255, 0));
        vecs.push_back(s(1, 0, 0, 0, 1, 0));
        for (int i = 0; i < 16; i++)
            vecs.push_back(b(1, int'(p8[7 - (i % 8)]), int'(i % 8 == 7), (i + 1) / 8, 1, 0));
        vecs.push_back(s(0, 1, 0, 2, 0, 0));
        // T6 prefix: arm and feed 1,0 before reset
        vecs.push_back(k(5, 3, 1, 0, 2, 0));
        vecs.push_back(s(1, 0, 0, 0, 1, 0));
        vecs.push_back(b(1, 1, 0, 0, 1, 0)); vecs.push_back(b(1, 0, 0, 0, 1, 0));

        #12;
        cmp("rst_out", 32'(out), 0);
        cmp("rst_cnt", 32'(match_cnt), 0);
        cmp("rst_busy", 32'(busy), 0);
        cmp("rst_done", 32'(done), 0);
        cmp("rst_err", 32'(cfg_err), 0);
        cmp("rst_ready", 32'(cfg_ready), 1);
        @(negedge clk);
        rst = 1;

        foreach (vecs[i]) drive(vecs[i]);
        drain();

        rst = 0;
        #1;
        cmp("mid_rst_out", 32'(out), 0);
        cmp("mid_rst_cnt", 32'(match_cnt), 0);
        cmp("mid_rst_busy", 32'(busy), 0);
        cmp("mid_rst_done", 32'(done), 0);
        cmp("mid_rst_ready", 32'(cfg_ready), 1);
        @(negedge clk);
        rst = 1;
        drive(s(1, 0, 0, 0, 0, 0));
        drive(b(1, 1, 0, 0, 0, 0));
        drive(b(1, 0, 0, 0, 0, 0));
        drive(b(1, 1, 0, 0, 0, 0));
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule
